time_set_ctrl: RTL and testbench



---
 rtl/time_set_pkg.sv | 32 +++
 rtl/time_set_ctrl_key_autorepeat.sv | 47 ++++
 rtl/time_set_ctrl.sv | 153 +++++++++++++++
 tb/tb_time_set_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/time_set_pkg.sv
// Shared types and constants for the time-setting controller.
package time_set_pkg;

  localparam int FIELD_W = 7;
  localparam logic [FIELD_W-1:0] MAX_HOURS   = 7'd23;
  localparam logic [FIELD_W-1:0] MAX_MINUTES = 7'd59;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EDIT_HR,
    ST_EDIT_MIN,
    ST_COMMIT
  } state_e;

  // Wrapping up/down step of one field; both or neither direction leaves it alone.
  function automatic logic [FIELD_W-1:0] step_field(
    input logic [FIELD_W-1:0] val,
    input logic [FIELD_W-1:0] lim,
    input logic               up,
    input logic               dn
  );
    logic [FIELD_W-1:0] res;
    res = val;
    if (up && !dn) begin
      res = (val == lim) ? '0 : val + 7'd1;
    end else if (dn && !up) begin
      res = (val == '0) ? lim : val - 7'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/time_set_ctrl_key_autorepeat.sv
// Auto-repeat generator for one held button: first tick after REPEAT_DELAY
// held cycles, then one every REPEAT_RATE cycles while held and enabled.
module key_autorepeat #(
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE  = 5_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic level,
  input  logic enable,
  output logic tick
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rep_q, rep_d;

  always_comb begin
    cnt_d = '0;
    rep_d = 1'b0;
    tick  = 1'b0;
    if (enable && level) begin
      cnt_d = cnt_q + 1'b1;
      rep_d = rep_q;
      // rep_q marks that the initial delay has elapsed and we are in the fast phase
      if ((!rep_q && cnt_q == CNT_W'(REPEAT_DELAY)) ||
          ( rep_q && cnt_q == CNT_W'(REPEAT_RATE))) begin
        tick  = 1'b1;
        cnt_d = CNT_W'(1);
        rep_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
      rep_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rep_q <= rep_d;
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting controller: captures live time, edits a shadow copy and writes it
// back with a one-cycle load strobe. Optional auto-repeat: TIME_SET_AUTOREPEAT_EN.
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 500_000_000,
  parameter int BLINK_CYCLES   = 12_500_000,
  parameter int REPEAT_DELAY   = 25_000_000,
  parameter int REPEAT_RATE    = 5_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode_tick,
  input  logic               up_tick,
  input  logic               down_tick,
  input  logic               up_level,
  input  logic               down_level,
  input  logic [FIELD_W-1:0] cur_hours,
  input  logic [FIELD_W-1:0] cur_minutes,
  output logic [FIELD_W-1:0] set_hours,
  output logic [FIELD_W-1:0] set_minutes,
  output logic               load_en,
  output logic               editing,
  output logic               edit_field,
  output logic               blink
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BL_W = $clog2(BLINK_CYCLES + 1);

  state_e             state_q, state_d;
  logic [FIELD_W-1:0] hours_q, hours_d, mins_q, mins_d;
  logic               load_q, load_d, edit_q, edit_d, field_q, field_d, blink_q, blink_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic [BL_W-1:0]    bl_q, bl_d;
  logic               rpt_up, rpt_dn;
  logic               up_any, dn_any, any_tick, in_edit;

`ifdef TIME_SET_AUTOREPEAT_EN
  logic rpt_en;
  // mode_tick drops enable so a field change always restarts the repeat delay
  assign rpt_en = (state_q == ST_EDIT_HR || state_q == ST_EDIT_MIN) &&
                  !(up_level && down_level) && !mode_tick;

  key_autorepeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_rpt_up (
    .clk    (clk),
    .reset  (reset),
    .level  (up_level),
    .enable (rpt_en),
    .tick   (rpt_up)
  );

  key_autorepeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_rpt_dn (
    .clk    (clk),
    .reset  (reset),
    .level  (down_level),
    .enable (rpt_en),
    .tick   (rpt_dn)
  );
`else
  localparam int unused_rpt_cfg = REPEAT_DELAY + REPEAT_RATE;
  logic unused_levels;
  assign unused_levels = up_level ^ down_level;
  assign rpt_up = 1'b0;
  assign rpt_dn = 1'b0;
`endif

  assign up_any   = up_tick | rpt_up;
  assign dn_any   = down_tick | rpt_dn;
  assign any_tick = mode_tick | up_any | dn_any;
  assign in_edit  = (state_q == ST_EDIT_HR) || (state_q == ST_EDIT_MIN);

  always_comb begin
    state_d = state_q;
    hours_d = hours_q;
    mins_d  = mins_q;
    to_d    = '0;
    case (state_q)
      ST_IDLE: begin
        if (mode_tick) begin
          hours_d = (cur_hours   > MAX_HOURS)   ? '0 : cur_hours;
          mins_d  = (cur_minutes > MAX_MINUTES) ? '0 : cur_minutes;
          state_d = ST_EDIT_HR;
        end
      end
      ST_EDIT_HR: begin
        if (mode_tick) state_d = ST_EDIT_MIN;
        else           hours_d = step_field(hours_q, MAX_HOURS, up_any, dn_any);
      end
      ST_EDIT_MIN: begin
        if (mode_tick) state_d = ST_COMMIT;
        else           mins_d  = step_field(mins_q, MAX_MINUTES, up_any, dn_any);
      end
      default: state_d = ST_IDLE;
    endcase

    // Inactivity abort: leaves the shadow values as they are and never strobes load
    if (in_edit && !mode_tick) begin
      if (any_tick)                            to_d = '0;
      else if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) state_d = ST_IDLE;
      else                                     to_d = to_q + 1'b1;
    end
  end

  always_comb begin
    bl_d    = '0;
    blink_d = 1'b0;
    if ((state_d == ST_EDIT_HR || state_d == ST_EDIT_MIN) &&
        state_d == state_q && !(up_any ^ dn_any)) begin
      if (bl_q == BL_W'(BLINK_CYCLES - 1)) begin
        blink_d = ~blink_q;
      end else begin
        bl_d    = bl_q + 1'b1;
        blink_d = blink_q;
      end
    end
    load_d  = (state_d == ST_COMMIT);
    edit_d  = (state_d == ST_EDIT_HR) || (state_d == ST_EDIT_MIN);
    field_d = (state_d == ST_EDIT_HR);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      hours_q <= '0;
      mins_q  <= '0;
      load_q  <= 1'b0;
      edit_q  <= 1'b0;
      field_q <= 1'b0;
      blink_q <= 1'b0;
      to_q    <= '0;
      bl_q    <= '0;
    end else begin
      state_q <= state_d;
      hours_q <= hours_d;
      mins_q  <= mins_d;
      load_q  <= load_d;
      edit_q  <= edit_d;
      field_q <= field_d;
      blink_q <= blink_d;
      to_q    <= to_d;
      bl_q    <= bl_d;
    end
  end

  assign set_hours   = hours_q;
  assign set_minutes = mins_q;
  assign load_en     = load_q;
  assign editing     = edit_q;
  assign edit_field  = field_q;
  assign blink       = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Randomized + directed bench for time_set_ctrl with a queue-based commit scoreboard.
module tb_time_set_ctrl;

  localparam int TO = 100;
  localparam int BL = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       mode_tick = 1'b0, up_tick = 1'b0, down_tick = 1'b0;
  logic       up_level = 1'b0, down_level = 1'b0;
  logic [6:0] cur_hours = '0, cur_minutes = '0;
  logic [6:0] set_hours, set_minutes;
  logic       load_en, editing, edit_field, blink;

  time_set_ctrl #(
    .TIMEOUT_CYCLES(TO), .BLINK_CYCLES(BL), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .reset(reset), .mode_tick(mode_tick), .up_tick(up_tick),
    .down_tick(down_tick), .up_level(up_level), .down_level(down_level),
    .cur_hours(cur_hours), .cur_minutes(cur_minutes), .set_hours(set_hours),
    .set_minutes(set_minutes), .load_en(load_en), .editing(editing),
    .edit_field(edit_field), .blink(blink)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_h[$];
  int exp_m[$];

  // Reference model: 0 idle, 1 hours, 2 minutes, 3 commit
  int m_st = 0, m_h = 0, m_m = 0, m_quiet = 0, m_age = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  task automatic model_edge(bit m, bit u, bit d);
    int delta;
    delta = (u && !d) ? 1 : ((d && !u) ? -1 : 0);
    case (m_st)
      0: if (m) begin
        m_h = (int'(cur_hours) > 23) ? 0 : int'(cur_hours);
        m_m = (int'(cur_minutes) > 59) ? 0 : int'(cur_minutes);
        m_st = 1; m_quiet = 0; m_age = 0;
      end
      1, 2: begin
        if (m) begin
          m_st = m_st + 1; m_quiet = 0; m_age = 0;
          if (m_st == 3) begin exp_h.push_back(m_h); exp_m.push_back(m_m); end
        end else begin
          if (delta != 0) begin
            if (m_st == 1) m_h = (m_h + delta + 24) % 24;
            else           m_m = (m_m + delta + 60) % 60;
            m_age = 0;
          end else m_age++;
          if (u || d) m_quiet = 0;
          else begin
            m_quiet++;
            if (m_quiet == TO) m_st = 0;
          end
        end
      end
      default: m_st = 0;
    endcase
  endtask

  function automatic void check_outputs();
    bit ed;
    ed = (m_st == 1 || m_st == 2);
    chk("set_hours", set_hours, m_h);
    chk("set_minutes", set_minutes, m_m);
    chk("editing", editing, ed);
    chk("edit_field", edit_field, m_st == 1);
    chk("load_en", load_en, m_st == 3);
    chk("blink", blink, ed ? (m_age / BL) % 2 : 0);
  endfunction

  task automatic cyc(bit m, bit u, bit d);
    mode_tick = m; up_tick = u; down_tick = d;
    @(posedge clk);
    model_edge(m, u, d);
    @(negedge clk);
    mode_tick = 1'b0; up_tick = 1'b0; down_tick = 1'b0;
    check_outputs();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    m_st = 0; m_h = 0; m_m = 0; m_quiet = 0; m_age = 0;
    @(negedge clk);
    reset = 1'b1;
    check_outputs();
  endtask

  // Scoreboard monitor: every load strobe must match the oldest expected commit
  always @(negedge clk) begin
    if (load_en === 1'b1) begin
      if (exp_h.size() == 0) chk("spurious_load_en", load_en, 0);
      else begin
        chk("commit_hours", set_hours, exp_h.pop_front());
        chk("commit_minutes", set_minutes, exp_m.pop_front());
      end
    end
  end

  initial begin
    @(negedge clk);
    do_reset();

    // Capture and commit
    cur_hours = 7'd13; cur_minutes = 7'd45;
    cyc(1, 0, 0); cyc(0, 1, 0); cyc(0, 1, 0); cyc(1, 0, 0); cyc(0, 0, 1); cyc(1, 0, 0);
    chk("t1_load", load_en, 1);
    chk("t1_hours", set_hours, 15);
    chk("t1_minutes", set_minutes, 44);
    cyc(0, 1, 0);
    chk("t1_idle_load", load_en, 0);
    chk("t1_idle_editing", editing, 0);

    // Wrap both directions
    cur_hours = 7'd23; cur_minutes = 7'd0;
    cyc(1, 0, 0); cyc(0, 1, 0); cyc(1, 0, 0); cyc(0, 0, 1);
    chk("t2_hours_wrap", set_hours, 0);
    chk("t2_minutes_wrap", set_minutes, 59);
    cyc(1, 0, 0); cyc(0, 0, 0);

    // Clamp and priority
    cur_hours = 7'd30; cur_minutes = 7'd70;
    cyc(1, 0, 0);
    chk("t3_clamp_h", set_hours, 0);
    chk("t3_clamp_m", set_minutes, 0);
    cyc(0, 1, 0);
    cyc(1, 1, 0);
    chk("t3_prio_field", edit_field, 0);
    chk("t3_prio_hours", set_hours, 1);
    cyc(0, 1, 0); cyc(0, 1, 1);
    chk("t3_both_minutes", set_minutes, 1);
    cyc(1, 0, 0); cyc(0, 0, 0);

    // Timeout abort
    cur_hours = 7'd8; cur_minutes = 7'd20;
    cyc(1, 0, 0);
    repeat (TO - 1) cyc(0, 0, 0);
    chk("t4_still_editing", editing, 1);
    cyc(0, 0, 0);
    chk("t4_timeout_editing", editing, 0);
    chk("t4_timeout_load", load_en, 0);
    cyc(0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        cur_hours = 7'($urandom_range(0, 127));
        cur_minutes = 7'($urandom_range(0, 127));
      end
      cyc($urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
    end
    repeat (3) cyc(0, 0, 0);
    if (m_st != 0) begin
      while (m_st != 0) cyc(1, 0, 0);
      cyc(0, 0, 0);
    end

    // Reset during the commit cycle
    cur_hours = 7'd12; cur_minutes = 7'd34;
    cyc(1, 0, 0); cyc(1, 0, 0); cyc(1, 0, 0);
    chk("t5_commit_load", load_en, 1);
    do_reset();
    chk("t5_reset_load", load_en, 0);
    chk("t5_reset_hours", set_hours, 0);
    chk("t5_reset_minutes", set_minutes, 0);

    // Auto-repeat hold in the minutes field
    cur_hours = 7'd5; cur_minutes = 7'd10;
    cyc(1, 0, 0); cyc(1, 0, 0);
    up_level = 1'b1;
    repeat (19) @(negedge clk);
    up_level = 1'b0;
    repeat (2) @(negedge clk);
`ifdef TIME_SET_AUTOREPEAT_EN
    chk("t6_repeat_minutes", set_minutes, 13);
`else
    chk("t6_repeat_minutes", set_minutes, 10);
`endif
    chk("t6_editing", editing, 1);
    do_reset();

    chk("scoreboard_drained", exp_h.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
